operand_fetch_stage: RTL and testbench

- Register-file and operand-latch stage directly upstream of the datapath function unit.
- Holds eight 16-bit general registers (R0-R7), reads two operands per issued instruction and applies the MB constant-select. Presents OpA/OpB/FS to the function unit, registered, one cycle after issue.
- Accepts the function unit's result and V/C/N/Z back as writeback, and keeps the architectural status register.

---
 rtl/operand_fetch_stage_if.sv | 48 ++++
 rtl/operand_fetch_stage.sv | 98 +++++++++
 tb/tb_operand_fetch_stage.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_stage_if.sv
// Operand-fetch stage bundle: issue request, writeback/status return and the registered operand outputs.
interface operand_fetch_stage_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  localparam int AW = $clog2(NREGS);

  logic             issue;
  logic             stall;
  logic [AW-1:0]    AA;
  logic [AW-1:0]    BA;
  logic [AW-1:0]    DA_in;
  logic [3:0]       FS_in;
  logic             MB;
  logic [WIDTH-1:0] const_in;

  logic             wb_en;
  logic [AW-1:0]    wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             sl;
  logic             wb_V;
  logic             wb_C;
  logic             wb_N;
  logic             wb_Z;

  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [3:0]       FS;
  logic [AW-1:0]    DA_ex;
  logic             ex_valid;
  logic             hazard;
  logic             V_q;
  logic             C_q;
  logic             N_q;
  logic             Z_q;

  modport master (
    output issue, stall, AA, BA, DA_in, FS_in, MB, const_in,
    output wb_en, wb_addr, wb_data, sl, wb_V, wb_C, wb_N, wb_Z,
    input  OpA, OpB, FS, DA_ex, ex_valid, hazard, V_q, C_q, N_q, Z_q
  );

  modport slave (
    input  issue, stall, AA, BA, DA_in, FS_in, MB, const_in,
    input  wb_en, wb_addr, wb_data, sl, wb_V, wb_C, wb_N, wb_Z,
    output OpA, OpB, FS, DA_ex, ex_valid, hazard, V_q, C_q, N_q, Z_q
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Register file + operand latch feeding the function unit; operands registered 1 cycle after issue.
// stall freezes the operand latch only; writeback and status load proceed regardless; hazard is advisory.
module operand_fetch_stage #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  operand_fetch_stage_if.slave ofs
);
  localparam int AW = $clog2(NREGS);

  typedef struct packed {
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [3:0]       fs;
    logic [AW-1:0]    da;
  } ex_t;

  typedef struct packed {
    logic v;
    logic c;
    logic n;
    logic z;
  } status_t;

  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;
  ex_t              ex_d;
  ex_t              ex_q;
  logic             ex_vld_q;
  status_t          st_q;

  // Same-cycle writeback is forwarded so an issuing instruction never reads stale data.
  always_comb begin
    rd_a = regs[ofs.AA];
    if (ofs.wb_en && (ofs.wb_addr == ofs.AA)) begin
      rd_a = ofs.wb_data;
    end
    rd_b = regs[ofs.BA];
    if (ofs.wb_en && (ofs.wb_addr == ofs.BA)) begin
      rd_b = ofs.wb_data;
    end
  end

  always_comb begin
    ex_d      = '0;
    ex_d.op_a = rd_a;
    ex_d.op_b = ofs.MB ? ofs.const_in : rd_b;
    ex_d.fs   = ofs.FS_in;
    ex_d.da   = ofs.DA_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (ofs.wb_en) begin
      regs[ofs.wb_addr] <= ofs.wb_data;
    end
  end

  // Idle cycles drop ex_valid but keep the operand payload visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      ex_vld_q <= 1'b0;
    end else if (!ofs.stall) begin
      ex_vld_q <= ofs.issue;
      if (ofs.issue) begin
        ex_q <= ex_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= '0;
    end else if (ofs.sl) begin
      st_q <= '{v: ofs.wb_V, c: ofs.wb_C, n: ofs.wb_N, z: ofs.wb_Z};
    end
  end

  assign ofs.hazard = ofs.issue & ex_vld_q &
                      ((ex_q.da == ofs.AA) | (~ofs.MB & (ex_q.da == ofs.BA)));

  assign ofs.OpA      = ex_q.op_a;
  assign ofs.OpB      = ex_q.op_b;
  assign ofs.FS       = ex_q.fs;
  assign ofs.DA_ex    = ex_q.da;
  assign ofs.ex_valid = ex_vld_q;
  assign ofs.V_q      = st_q.v;
  assign ofs.C_q      = st_q.c;
  assign ofs.N_q      = st_q.n;
  assign ofs.Z_q      = st_q.z;
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench: driver pushes model expectations per cycle, monitor pops and compares.
module tb_operand_fetch_stage;
  logic clk;
  logic rst_n;

  operand_fetch_stage_if ofs_if ();

  operand_fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ofs   (ofs_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        hz;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fs;
    logic [2:0]  da;
    logic        v;
    logic [3:0]  st;
  } exp_t;

  exp_t q[$];

  int n_vec = 0;
  int n_bad = 0;

  // Reference machine state
  logic [15:0] m_regs [8];
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [3:0]  m_fs;
  logic [2:0]  m_da;
  logic        m_v;
  logic [3:0]  m_st;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) m_regs[i] = 16'h0000;
    m_a  = 16'h0000;
    m_b  = 16'h0000;
    m_fs = 4'h0;
    m_da = 3'h0;
    m_v  = 1'b0;
    m_st = 4'h0;
  endfunction

  task automatic drive_idle();
    ofs_if.issue    = 1'b0;
    ofs_if.stall    = 1'b0;
    ofs_if.AA       = 3'd0;
    ofs_if.BA       = 3'd0;
    ofs_if.DA_in    = 3'd0;
    ofs_if.FS_in    = 4'd0;
    ofs_if.MB       = 1'b0;
    ofs_if.const_in = 16'h0000;
    ofs_if.wb_en    = 1'b0;
    ofs_if.wb_addr  = 3'd0;
    ofs_if.wb_data  = 16'h0000;
    ofs_if.sl       = 1'b0;
    ofs_if.wb_V     = 1'b0;
    ofs_if.wb_C     = 1'b0;
    ofs_if.wb_N     = 1'b0;
    ofs_if.wb_Z     = 1'b0;
  endtask

  // One clock of stimulus; flags are {V,C,N,Z}.
  task automatic cyc(input logic iss, input logic stl, input logic [2:0] aa, input logic [2:0] ba,
                     input logic [2:0] da, input logic [3:0] fs, input logic mb, input logic [15:0] cst,
                     input logic we, input logic [2:0] wa, input logic [15:0] wd,
                     input logic sl_i, input logic [3:0] flags);
    exp_t        e;
    logic [15:0] ra;
    logic [15:0] rb;
    @(negedge clk);
    ofs_if.issue    = iss;
    ofs_if.stall    = stl;
    ofs_if.AA       = aa;
    ofs_if.BA       = ba;
    ofs_if.DA_in    = da;
    ofs_if.FS_in    = fs;
    ofs_if.MB       = mb;
    ofs_if.const_in = cst;
    ofs_if.wb_en    = we;
    ofs_if.wb_addr  = wa;
    ofs_if.wb_data  = wd;
    ofs_if.sl       = sl_i;
    ofs_if.wb_V     = flags[3];
    ofs_if.wb_C     = flags[2];
    ofs_if.wb_N     = flags[1];
    ofs_if.wb_Z     = flags[0];

    ra = (we && wa == aa) ? wd : m_regs[aa];
    if (mb) rb = cst;
    else    rb = (we && wa == ba) ? wd : m_regs[ba];

    e.hz = iss && m_v && ((m_da == aa) || (!mb && (m_da == ba)));
    if (!stl) begin
      if (iss) begin
        m_a  = ra;
        m_b  = rb;
        m_fs = fs;
        m_da = da;
      end
      m_v = iss;
    end
    if (we)   m_regs[wa] = wd;
    if (sl_i) m_st = flags;

    e.a  = m_a;
    e.b  = m_b;
    e.fs = m_fs;
    e.da = m_da;
    e.v  = m_v;
    e.st = m_st;
    q.push_back(e);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'd0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_opa"}, {16'h0, ofs_if.OpA}, 32'h0);
    chk({tag, "_opb"}, {16'h0, ofs_if.OpB}, 32'h0);
    chk({tag, "_fs"}, {28'h0, ofs_if.FS}, 32'h0);
    chk({tag, "_da"}, {29'h0, ofs_if.DA_ex}, 32'h0);
    chk({tag, "_exv"}, {31'h0, ofs_if.ex_valid}, 32'h0);
    chk({tag, "_stat"}, {28'h0, ofs_if.V_q, ofs_if.C_q, ofs_if.N_q, ofs_if.Z_q}, 32'h0);
  endtask

  // Monitor: hazard sampled mid-cycle, registered outputs just after the edge.
  initial begin
    logic hz_s;
    exp_t e;
    hz_s = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      hz_s = ofs_if.hazard;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("hazard", {31'h0, hz_s}, {31'h0, e.hz});
        chk("OpA", {16'h0, ofs_if.OpA}, {16'h0, e.a});
        chk("OpB", {16'h0, ofs_if.OpB}, {16'h0, e.b});
        chk("FS", {28'h0, ofs_if.FS}, {28'h0, e.fs});
        chk("DA_ex", {29'h0, ofs_if.DA_ex}, {29'h0, e.da});
        chk("ex_valid", {31'h0, ofs_if.ex_valid}, {31'h0, e.v});
        chk("status", {28'h0, ofs_if.V_q, ofs_if.C_q, ofs_if.N_q, ofs_if.Z_q}, {28'h0, e.st});
      end
    end
  end

  initial begin
    logic [2:0]  r_aa, r_ba, r_da, r_wa;
    logic [3:0]  r_fs, r_fl;
    logic [15:0] r_cst, r_wd;
    logic        r_iss, r_stl, r_mb, r_we, r_sl;

    rst_n = 1'b0;
    drive_idle();
    model_reset();
    #12;
    check_all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic read after write
    cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 16'h0, 1'b1, 3'd3, 16'h1234, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 3'd3, 3'd3, 3'd0, 4'h0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    idle();

    // Same-cycle bypass with constant B, then R5 read back
    cyc(1'b1, 1'b0, 3'd5, 3'd0, 3'd1, 4'h3, 1'b1, 16'h0007, 1'b1, 3'd5, 16'hBEEF, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 3'd5, 3'd5, 3'd2, 4'h4, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);

    // Stall holds the latch while writeback still lands
    cyc(1'b1, 1'b0, 3'd3, 3'd5, 3'd6, 4'hA, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 3'd1, 3'd1, 3'd7, 4'h5, 1'b1, 16'h5555, 1'b1, 3'd2, 16'h00FF, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 3'd4, 3'd0, 3'd7, 4'h6, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    cyc(1'b1, 1'b1, 3'd0, 3'd2, 3'd1, 4'h7, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 3'd2, 3'd2, 3'd0, 4'h1, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);

    // Status load then hold
    cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b1, 4'b1010);
    cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'b0101);

    // Hazard: A match flags, B match with MB=1 does not
    cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd4, 4'h2, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 3'd4, 3'd0, 3'd4, 4'h2, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 3'd1, 3'd4, 3'd3, 4'h2, 1'b1, 16'h0042, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 3'd0, 3'd3, 3'd0, 4'h2, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r_iss = ($urandom_range(99) < 65);
      r_stl = ($urandom_range(99) < 20);
      r_aa  = 3'($urandom_range(7));
      r_ba  = 3'($urandom_range(7));
      r_da  = 3'($urandom_range(7));
      r_fs  = 4'($urandom_range(15));
      r_mb  = 1'($urandom_range(1));
      r_cst = 16'($urandom);
      r_we  = ($urandom_range(99) < 50);
      r_wa  = 3'($urandom_range(7));
      r_wd  = 16'($urandom);
      r_sl  = ($urandom_range(99) < 30);
      r_fl  = 4'($urandom_range(15));
      cyc(r_iss, r_stl, r_aa, r_ba, r_da, r_fs, r_mb, r_cst, r_we, r_wa, r_wd, r_sl, r_fl);
    end

    // Load state, then asynchronous reset between edges
    cyc(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 16'h0, 1'b1, 3'd0, 16'hA5A5, 1'b0, 4'h0);
    cyc(1'b1, 1'b0, 3'd0, 3'd0, 3'd5, 4'h9, 1'b0, 16'h0, 1'b1, 3'd7, 16'h7777, 1'b1, 4'b1111);
    @(posedge clk);
    #3;
    drive_idle();
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < 8; r++) begin
      cyc(1'b1, 1'b0, 3'(r), 3'(r), 3'(r), 4'h0, 1'b0, 16'h0, 1'b0, 3'd0, 16'h0, 1'b0, 4'h0);
    end
    idle();

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
